// File: rtl/wave_pkg.sv
// Shared geometry, sample format and stream types for the waveform overlay stage.
package wave_pkg;

    localparam int unsigned X_START   = 442;
    localparam int unsigned Y_TOP     = 32;
    localparam int unsigned Y_BOT     = 1055;
    localparam int unsigned PLOT_W    = 1024;
    localparam int unsigned SAMPLE_W  = 8;
    localparam int unsigned ROW_SHIFT = 2;
    localparam int unsigned LAT       = 3;
    localparam int unsigned CNT_W     = 12;

    localparam logic [23:0] TRACE_COLOR_DEF = 24'hFFFF00;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] data;
    } video_t;

    // Screen row of an ADC code: code 0 sits on the bottom plot row.
    function automatic logic [10:0] sample_row(input logic [SAMPLE_W-1:0] s);
        return 11'(Y_BOT) - (11'(s) << ROW_SHIFT);
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// N-stage register delay of a video beat (sync, enable and RGB) with synchronous reset.
module video_delay_line
    import wave_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  video_t in_i,
    output video_t out_o
);

    video_t pipe_q [N];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(N); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= in_i;
            for (int i = 1; i < int'(N); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign out_o = pipe_q[N-1];

endmodule

// File: rtl/wave_display.sv
// Draws the captured ADC waveform as a continuous trace over the grid video stream,
// reading samples from a double-banked RAM that is swapped at frame start.
module wave_display
    import wave_pkg::*;
#(
    parameter logic [23:0] TRACE_COLOR = TRACE_COLOR_DEF
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                i_hs,
    input  logic                i_vs,
    input  logic                i_de,
    input  logic [23:0]         i_data,
    input  logic                trace_en,
    input  logic                buf_ready,
    output logic                buf_ack,
    output logic [10:0]         ram_addr,
    input  logic [SAMPLE_W-1:0] ram_rdata,
    output logic                o_hs,
    output logic                o_vs,
    output logic                o_de,
    output logic [23:0]         o_data
);

    localparam logic [CNT_W-1:0] XLo = CNT_W'(X_START);
    localparam logic [CNT_W-1:0] XHi = CNT_W'(X_START + PLOT_W - 1);
    localparam logic [CNT_W-1:0] YLo = CNT_W'(Y_TOP);
    localparam logic [CNT_W-1:0] YHi = CNT_W'(Y_BOT);

    logic             vs_prev_q, de_prev_q;
    logic [CNT_W-1:0] x_q, y_q;
    logic             synced_q, trace_on_q, have_buf_q, rd_bank_q, buf_ack_q;
    logic [10:0]      ram_addr_q;
    logic             p1_plot_q, p1_first_q, p2_plot_q;
    logic [CNT_W-1:0] p1_y_q, p2_y_q;
    logic [10:0]      cur_row_q, prev_row_q;
    logic             draw_q, draw_d;

    logic        vs_rise, in_plot;
    logic [9:0]  x_off;
    logic [10:0] row_now, row_lo, row_hi;
    video_t      vid_in, vid_out;

    assign vs_rise = i_vs & ~vs_prev_q;
    assign in_plot = i_de && (x_q >= XLo) && (x_q <= XHi);
    assign x_off   = 10'(x_q - XLo);
    assign row_now = sample_row(ram_rdata);

    always_comb begin
        row_lo = (prev_row_q < cur_row_q) ? prev_row_q : cur_row_q;
        row_hi = (prev_row_q < cur_row_q) ? cur_row_q : prev_row_q;
        draw_d = p2_plot_q && synced_q && trace_on_q && have_buf_q
              && (p2_y_q >= YLo) && (p2_y_q <= YHi)
              && (p2_y_q >= {1'b0, row_lo}) && (p2_y_q <= {1'b0, row_hi});
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            synced_q   <= 1'b0;
            trace_on_q <= 1'b0;
            have_buf_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            buf_ack_q  <= 1'b0;
            ram_addr_q <= '0;
            p1_plot_q  <= 1'b0;
            p1_first_q <= 1'b0;
            p1_y_q     <= '0;
            p2_plot_q  <= 1'b0;
            p2_y_q     <= '0;
            cur_row_q  <= '0;
            prev_row_q <= '0;
            draw_q     <= 1'b0;
        end else begin
            vs_prev_q <= i_vs;
            de_prev_q <= i_de;
            x_q       <= i_de ? x_q + CNT_W'(1) : '0;
            if (vs_rise) begin
                y_q <= '0;
            end else if (de_prev_q && !i_de) begin
                y_q <= y_q + CNT_W'(1);
            end

            // Bank ownership only changes at frame start, never mid-frame.
            buf_ack_q <= vs_rise && buf_ready;
            if (vs_rise) begin
                synced_q   <= 1'b1;
                trace_on_q <= trace_en;
                if (buf_ready) begin
                    rd_bank_q  <= ~rd_bank_q;
                    have_buf_q <= 1'b1;
                end
            end

            if (in_plot) begin
                ram_addr_q <= {rd_bank_q, x_off};
            end
            p1_plot_q  <= in_plot;
            p1_first_q <= (x_q == XLo);
            p1_y_q     <= y_q;

            // ram_rdata now belongs to the pixel held in stage 1.
            p2_plot_q <= p1_plot_q;
            p2_y_q    <= p1_y_q;
            if (p1_plot_q) begin
                cur_row_q  <= row_now;
                prev_row_q <= p1_first_q ? row_now : cur_row_q;
            end

            draw_q <= draw_d;
        end
    end

    assign vid_in = '{hs: i_hs, vs: i_vs, de: i_de, data: i_data};

    video_delay_line #(
        .N(LAT)
    ) u_delay (
        .clk_i(pclk),
        .rst_i(rst),
        .in_i (vid_in),
        .out_o(vid_out)
    );

    assign buf_ack  = buf_ack_q;
    assign ram_addr = ram_addr_q;
    assign o_hs     = vid_out.hs;
    assign o_vs     = vid_out.vs;
    assign o_de     = vid_out.de;
    assign o_data   = draw_q ? TRACE_COLOR : vid_out.data;

endmodule

// File: tb/tb_wave_display.sv
// Bench for wave_display: scripted frames with random pixels and samples, checked
// per cycle against a frame-level model of the trace geometry and bank handshake.
module tb_wave_display;

    localparam logic [23:0] TC = 24'hFFFF00;

    logic        pclk = 1'b0;
    logic        rst;
    logic        i_hs, i_vs, i_de;
    logic [23:0] i_data;
    logic        trace_en, buf_ready, buf_ack;
    logic [10:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic        o_hs, o_vs, o_de;
    logic [23:0] o_data;

    logic [7:0] mem [0:2047];
    assign ram_rdata = mem[ram_addr];

    always #5 pclk = ~pclk;

    wave_display dut (
        .pclk     (pclk),
        .rst      (rst),
        .i_hs     (i_hs),
        .i_vs     (i_vs),
        .i_de     (i_de),
        .i_data   (i_data),
        .trace_en (trace_en),
        .buf_ready(buf_ready),
        .buf_ack  (buf_ack),
        .ram_addr (ram_addr),
        .ram_rdata(ram_rdata),
        .o_hs     (o_hs),
        .o_vs     (o_vs),
        .o_de     (o_de),
        .o_data   (o_data)
    );

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] data;
        bit          r;
    } ent_t;

    ent_t h0, h1, h2;
    int   n_cmp, n_fail;
    bit   m_synced, m_trace_on, m_have_buf, m_bank;
    bit   full_row [0:1079];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Trace geometry straight from the sample rows of the bank being drawn.
    function automatic bit exp_draw(input int x, input int y);
        int i, cur, prv, lo, hi;
        if (x < 442 || x > 1465 || y < 32 || y > 1055) return 1'b0;
        if (!(m_synced && m_trace_on && m_have_buf)) return 1'b0;
        i   = x - 442;
        cur = 1055 - 4 * int'(mem[int'(m_bank) * 1024 + i]);
        prv = (i == 0) ? cur : 1055 - 4 * int'(mem[int'(m_bank) * 1024 + i - 1]);
        lo  = (prv < cur) ? prv : cur;
        hi  = (prv < cur) ? cur : prv;
        return (y >= lo) && (y <= hi);
    endfunction

    task automatic step(input logic hs, input logic vs, input logic de, input logic [23:0] d,
                        input bit drw, input bit r, input bit ack, input bit achk,
                        input logic [10:0] aexp);
        ent_t e;
        i_hs = hs; i_vs = vs; i_de = de; i_data = d; rst = r;
        @(posedge pclk);
        #1;
        h2 = h1;
        h1 = h0;
        h0 = '{hs: hs, vs: vs, de: de, data: (drw ? TC : d), r: r};
        if (h0.r || h1.r || h2.r) e = '{hs: 1'b0, vs: 1'b0, de: 1'b0, data: 24'h0, r: 1'b0};
        else e = h2;
        chk("o_hs", 32'(o_hs), 32'(e.hs));
        chk("o_vs", 32'(o_vs), 32'(e.vs));
        chk("o_de", 32'(o_de), 32'(e.de));
        chk("o_data", 32'(o_data), 32'(e.data));
        chk("buf_ack", 32'(buf_ack), 32'(ack && !r));
        if (r) chk("ram_addr_rst", 32'(ram_addr), 32'h0);
        else if (achk) chk("ram_addr", 32'(ram_addr), 32'(aexp));
    endtask

    task automatic blank(input logic hs, input logic vs);
        step(hs, vs, 1'b0, 24'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    endtask

    task automatic pix(input int x, input int y);
        bit inr;
        inr = (x >= 442) && (x <= 1465);
        step(1'b0, 1'b0, 1'b1, 24'($urandom), exp_draw(x, y), 1'b0, 1'b0, inr,
             11'(int'(m_bank) * 1024 + (inr ? x - 442 : 0)));
    endtask

    // One frame: rows flagged in full_row carry len pixels, the rest a single pixel.
    task automatic frame(input bit ten, input bit brd, input int len, input int rst_line);
        trace_en  = ten;
        buf_ready = brd;
        step(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0, 1'b0, brd, 1'b0, 11'h0);
        m_synced   = 1'b1;
        m_trace_on = ten;
        if (brd) begin
            m_bank     = ~m_bank;
            m_have_buf = 1'b1;
        end
        blank(1'b1, 1'b1);
        trace_en = ~ten;  // only the frame-start value may matter
        blank(1'b0, 1'b0);
        blank(1'b0, 1'b0);
        for (int y = 0; y < 1080; y++) begin
            if (y == rst_line) begin
                m_synced   = 1'b0;
                m_trace_on = 1'b0;
                m_have_buf = 1'b0;
                m_bank     = 1'b0;
                repeat (2) step(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 11'h0);
            end
            for (int x = 0; x < (full_row[y] ? len : 1); x++) pix(x, y);
            blank(1'b1, 1'b0);
            blank(1'b0, 1'b0);
        end
        for (int y = 0; y < 1080; y++) full_row[y] = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_data = 24'h0;
        trace_en = 1'b0; buf_ready = 1'b0;
        h0 = '{hs: 1'b0, vs: 1'b0, de: 1'b0, data: 24'h0, r: 1'b1};
        h1 = h0;
        h2 = h0;
        m_synced = 1'b0; m_trace_on = 1'b0; m_have_buf = 1'b0; m_bank = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int y = 0; y < 1080; y++) full_row[y] = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0);

        // Pass-through, no buffer offered, wide line past the plot.
        full_row[100] = 1'b1;
        full_row[1056] = 1'b1;
        frame(1'b0, 1'b0, 1480, -1);

        // Flat trace at row 543 from bank 1.
        for (int i = 0; i < 1024; i++) mem[1024 + i] = 8'h80;
        full_row[31] = 1'b1; full_row[542] = 1'b1; full_row[543] = 1'b1;
        full_row[544] = 1'b1; full_row[1056] = 1'b1;
        frame(1'b1, 1'b1, 1480, -1);

        // Vertical fill between a bottom and a top code in bank 0.
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'hFF;
        full_row[34] = 1'b1; full_row[35] = 1'b1; full_row[36] = 1'b1; full_row[700] = 1'b1;
        full_row[1055] = 1'b1; full_row[1056] = 1'b1; full_row[1079] = 1'b1;
        frame(1'b1, 1'b1, 470, -1);

        // No new buffer: bank 0 redrawn while bank 1 is being refilled.
        for (int i = 0; i < 1024; i++) mem[1024 + i] = 8'($urandom);
        full_row[35] = 1'b1; full_row[1055] = 1'b1;
        repeat (2) full_row[$urandom_range(1055, 32)] = 1'b1;
        frame(1'b1, 1'b0, 1480, -1);

        // Mid-frame reset at line 500.
        full_row[499] = 1'b1; full_row[500] = 1'b1; full_row[501] = 1'b1;
        frame(1'b1, 1'b1, 1480, 500);

        // Recovery frame draws bank 1 after a fresh ack.
        repeat (3) full_row[$urandom_range(1055, 32)] = 1'b1;
        frame(1'b1, 1'b1, 1480, -1);

        // Ack with the overlay disabled.
        full_row[$urandom_range(1055, 32)] = 1'b1;
        frame(1'b0, 1'b1, 600, -1);

        repeat (4) blank(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
